me_window_fifo: RTL and testbench

ME_WINDOW_FIFO -- requirements
Module: me_window_fifo

---
 rtl/me_pkg.sv | 11 +
 rtl/me_window_slice.sv | 19 +
 rtl/me_window_fifo.sv | 92 +++++++++
 tb/tb_me_window_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared defaults and row-width helper for the motion-estimation window FIFO.
package me_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int BLK_DEF   = 16;
  localparam int NWIN_DEF  = 8;

  // A row spans every pixel touched by the NWIN overlapping windows.
  function automatic int ROW_W(input int blk, input int nwin, input int pix_w);
    return (blk + nwin - 1) * pix_w;
  endfunction
endpackage

// File: rtl/me_window_slice.sv
// Cuts one search row into NWIN overlapping BLK-pixel windows; purely combinational.
// Window k starts at pixel k; pixel 0 and window 0 both sit in the MSBs.
module me_window_slice import me_pkg::*; #(
  parameter int PIX_W = PIX_W_DEF,
  parameter int BLK   = BLK_DEF,
  parameter int NWIN  = NWIN_DEF,
  localparam int ROW_PIX   = BLK + NWIN - 1,
  localparam int ROW_WIDTH = ROW_W(BLK, NWIN, PIX_W),
  localparam int WIN_WIDTH = NWIN * BLK * PIX_W
) (
  input  logic [ROW_WIDTH-1:0] row_i,
  output logic [WIN_WIDTH-1:0] win_o
);

  for (genvar k = 0; k < NWIN; k++) begin : g_win
    assign win_o[(NWIN-k)*BLK*PIX_W-1 -: BLK*PIX_W] = row_i[(ROW_PIX-k)*PIX_W-1 -: BLK*PIX_W];
  end

endmodule

// File: rtl/me_window_fifo.sv
// Row FIFO presenting the head row as NWIN overlapping windows; one-cycle write-to-output latency.
// in_ready_o drops only when full (no path from out_ready_i); pushes while full set sticky ovf_o.
module me_window_fifo import me_pkg::*; #(
  parameter int PIX_W = PIX_W_DEF,
  parameter int BLK   = BLK_DEF,
  parameter int NWIN  = NWIN_DEF,
  parameter int DEPTH = 4,
  localparam int ROW_WIDTH = ROW_W(BLK, NWIN, PIX_W),
  localparam int WIN_WIDTH = NWIN * BLK * PIX_W,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [ROW_WIDTH-1:0] row_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIN_WIDTH-1:0] win_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 ovf_o
);

  logic [ROW_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 full, empty, push, pop;
  logic [WIN_WIDTH-1:0] win_raw;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid_i && !full;
  assign pop   = out_ready_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (in_valid_i && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left unreset; the pointers alone decide what is visible.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i && !rst_i) mem_q[wr_ptr_q] <= row_i;
  end

  me_window_slice #(
    .PIX_W (PIX_W),
    .BLK   (BLK),
    .NWIN  (NWIN)
  ) u_slice (
    .row_i (mem_q[rd_ptr_q]),
    .win_o (win_raw)
  );

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign count_o     = count_q;
  assign ovf_o       = ovf_q;
  assign win_o       = empty ? '0 : win_raw;

endmodule

// File: tb/tb_me_window_fifo.sv
// Directed plus randomized bench for me_window_fifo against a queue-based reference model.
module tb_me_window_fifo;
  localparam int PIX_W   = 8;
  localparam int BLK     = 16;
  localparam int NWIN    = 8;
  localparam int DEPTH   = 4;
  localparam int ROW_PIX = BLK + NWIN - 1;
  localparam int ROW_W   = ROW_PIX * PIX_W;
  localparam int WIN_W   = NWIN * BLK * PIX_W;
  localparam int B2      = 8;
  localparam int N2      = 4;
  localparam int RP2     = B2 + N2 - 1;
  localparam int RW2     = RP2 * PIX_W;
  localparam int WW2     = N2 * B2 * PIX_W;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [WIN_W-1:0] win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, in_valid, out_ready;
  logic       in_ready, out_valid, ovf;
  row_t       row;
  win_t       win;
  logic [2:0] count;

  logic             rst2, flush2, in_valid2, out_ready2;
  logic             in_ready2, out_valid2, ovf2;
  logic [RW2-1:0]   row2;
  logic [WW2-1:0]   win2;
  logic [2:0]       count2;

  me_window_fifo #(.PIX_W(PIX_W), .BLK(BLK), .NWIN(NWIN), .DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .row_i(row), .out_valid_o(out_valid), .out_ready_i(out_ready), .win_o(win),
    .count_o(count), .ovf_o(ovf)
  );

  me_window_fifo #(.PIX_W(PIX_W), .BLK(B2), .NWIN(N2), .DEPTH(DEPTH)) u_dut2 (
    .clk_i(clk), .rst_i(rst2), .flush_i(flush2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .row_i(row2), .out_valid_o(out_valid2), .out_ready_i(out_ready2), .win_o(win2),
    .count_o(count2), .ovf_o(ovf2)
  );

  int   errors = 0;
  int   checks = 0;
  row_t q[$];
  logic m_ovf = 1'b0;

  function automatic logic [7:0] pix(input row_t r, input int i);
    return r[(ROW_PIX-1-i)*PIX_W +: PIX_W];
  endfunction

  function automatic row_t set_pix(input row_t r, input int i, input logic [7:0] v);
    row_t t;
    t = r;
    t[(ROW_PIX-1-i)*PIX_W +: PIX_W] = v;
    return t;
  endfunction

  function automatic row_t ramp_row(input int start);
    row_t r;
    r = '0;
    for (int i = 0; i < ROW_PIX; i++) r = set_pix(r, i, 8'(start + i));
    return r;
  endfunction

  function automatic row_t rand_row(input int head, input bit fix_head);
    row_t r;
    r = '0;
    for (int i = 0; i < ROW_PIX; i++) r = set_pix(r, i, 8'($urandom));
    if (fix_head) r = set_pix(r, 0, 8'(head));
    return r;
  endfunction

  // Window k, byte j (MSB first) is row pixel k+j.
  function automatic win_t exp_win(input row_t r);
    win_t w;
    w = '0;
    for (int k = 0; k < NWIN; k++)
      for (int j = 0; j < BLK; j++)
        w[((NWIN-k)*BLK-1-j)*PIX_W +: PIX_W] = pix(r, k + j);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    win_t ew;
    ew = (q.size() != 0) ? exp_win(q[0]) : '0;
    chk({tag, ".count"}, 1024'(count), 1024'(q.size()));
    chk({tag, ".in_ready"}, 1024'(in_ready), 1024'(q.size() != DEPTH));
    chk({tag, ".out_valid"}, 1024'(out_valid), 1024'(q.size() != 0));
    chk({tag, ".ovf"}, 1024'(ovf), 1024'(m_ovf));
    chk({tag, ".win"}, 1024'(win), 1024'(ew));
  endtask

  task automatic step(input string tag, input logic v, input row_t r, input logic rdy,
                      input logic fl, input logic rs);
    bit was_full, was_empty;
    in_valid = v; row = r; out_ready = rdy; flush = fl; rst = rs;
    @(posedge clk);
    if (rs || fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (v && was_full) m_ovf = 1'b1;
      if (rdy && !was_empty) void'(q.pop_front());
      if (v && !was_full) q.push_back(r);
    end
    #1;
    check_outputs(tag);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [RW2-1:0] r2;
    logic [WW2-1:0] e2;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; row = '0;
    rst2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; row2 = '0;

    step("reset", 0, '0, 0, 0, 1);
    step("reset2", 0, '0, 1, 0, 1);

    // Ramp row: single push visible after one edge.
    step("ramp", 1, ramp_row(0), 0, 0, 0);
    chk("ramp.w0", 1024'(win[WIN_W-1 -: BLK*PIX_W]), 1024'(128'h000102030405060708090a0b0c0d0e0f));
    chk("ramp.w3_first", 1024'(win[(NWIN-3)*BLK*PIX_W-1 -: 8]), 1024'(8'h03));
    chk("ramp.w3_last", 1024'(win[(NWIN-4)*BLK*PIX_W +: 8]), 1024'(8'h12));
    chk("ramp.w7_last", 1024'(win[7:0]), 1024'(8'h16));
    step("ramp_pop", 0, '0, 1, 0, 0);

    // Fill, then overflow attempt, then sticky check.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, rand_row(0, 0), 0, 0, 0);
    step("ovf_push", 1, rand_row(0, 0), 0, 0, 0);
    step("ovf_hold", 0, '0, 0, 0, 0);

    // Full with both sides active: only the pop happens, then push+pop.
    step("full_both", 1, rand_row(0, 0), 1, 0, 0);
    chk("full_both.cnt3", 1024'(count), 1024'(3));
    step("both_again", 1, rand_row(0, 0), 1, 0, 0);
    chk("both_again.cnt3", 1024'(count), 1024'(3));

    // Pointer wrap with head bytes 00,11,22,...
    step("flush0", 0, '0, 0, 1, 0);
    step("wrap", 1, rand_row(8'h00, 1), 0, 0, 0);
    step("wrap", 1, rand_row(8'h11, 1), 0, 0, 0);
    for (int n = 2; n < 6; n++) begin
      step("wrap", 1, rand_row(8'h11 * n, 1), 1, 0, 0);
      chk("wrap.head", 1024'(win[WIN_W-1 -: 8]), 1024'(8'(8'h11 * (n - 1))));
    end
    step("wrap_drain", 0, '0, 1, 0, 0);
    chk("wrap.head5", 1024'(win[WIN_W-1 -: 8]), 1024'(8'h55));
    step("wrap_drain", 0, '0, 1, 0, 0);

    // Flush discards a coincident push.
    step("pre_flush", 1, rand_row(0, 0), 0, 0, 0);
    step("pre_flush", 1, rand_row(0, 0), 0, 0, 0);
    step("flush_push", 1, rand_row(0, 0), 0, 1, 0);

    // Reset mid-stream, overriding flush and handshakes.
    for (int i = 0; i < 3; i++) step("pre_rst", 1, rand_row(0, 0), 0, 0, 0);
    step("rst_mid", 1, rand_row(0, 0), 1, 1, 1);
    step("post_rst", 1, ramp_row(0), 0, 0, 0);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom), rand_row(0, 0), 1'($urandom),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0));

    // Second parameter set: BLK=8, NWIN=4.
    @(posedge clk); #1;
    chk("p2.rst_cnt", 1024'(count2), 1024'(0));
    chk("p2.rst_win", 1024'(win2), 1024'(0));
    chk("p2.rst_rdy", 1024'(in_ready2), 1024'(1));
    rst2 = 1'b0;
    for (int i = 0; i < RP2; i++) r2[(RP2-1-i)*PIX_W +: PIX_W] = 8'(i);
    row2 = r2; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    e2 = '0;
    for (int k = 0; k < N2; k++)
      for (int j = 0; j < B2; j++)
        e2[((N2-k)*B2-1-j)*PIX_W +: PIX_W] = 8'(k + j);
    chk("p2.valid", 1024'(out_valid2), 1024'(1));
    chk("p2.cnt", 1024'(count2), 1024'(1));
    chk("p2.win", 1024'(win2), 1024'(e2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
